// File: rtl/pulse_checker_pkg.sv
// Shared basis definitions for the start-pulse generator / checker pair.
package pulse_checker_pkg;

  // Checker FSM encoding; the values are visible on the debug state port.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STUCK   = 2'd2
  } pc_state_t;

  // Nominal start-pulse width shared by the generator and the checker.
  localparam int PULSE_LENGTH_DEF = 3;

  // Bits needed to hold the values 0 .. max_len+1.
  function automatic int cnt_width(input int max_len);
    int w;
    w = $clog2(max_len + 2);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pulse_checker.sv
// Measures each high pulse on Stin and turns it into a one-cycle Stout
// (width inside the accepted window) or a one-cycle Err (too short/too long).
//
// Handshake: there is no valid/ready pair here. Stin is a level that is
// sampled every rising CLK edge; Stout and Err are single-cycle strobes with
// no back-pressure, and the consumer must take them in the cycle they appear.
module pulse_checker
  import pulse_checker_pkg::*;
#(
  parameter int pulse_length = PULSE_LENGTH_DEF,
  parameter int tolerance    = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Stin,
  output logic       Stout,
  output logic       Err,
  output logic       Busy,
  output logic [1:0] dbg_state
);

  localparam int MIN_LEN = pulse_length - tolerance;
  localparam int MAX_LEN = pulse_length + tolerance;
  localparam int CNT_W   = cnt_width(MAX_LEN);

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_LEN);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  pc_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             stold;
  logic             stout_n, err_n;

  // State register; reset returns to IDLE without finishing any pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Edge-detect history, width counter and registered strobes. stold resets
  // high so a pulse already present at reset release is not mistaken for a
  // fresh rising edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stold <= 1'b1;
      cnt   <= '0;
      Stout <= 1'b0;
      Err   <= 1'b0;
    end else begin
      stold <= Stin;
      cnt   <= cnt_n;
      Stout <= stout_n;
      Err   <= err_n;
    end
  end

  // Next-state, counter update and strobe decisions.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stout_n = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (Stin && !stold) begin
          cnt_n   = ONE_C;
          state_n = MEASURE;
        end
      end
      MEASURE: begin
        if (Stin) begin
          // Counter saturates at MAX_LEN: the pulse is already too long, so
          // flag it once and wait out the rest of it in STUCK.
          if (cnt == MAX_C) begin
            err_n   = 1'b1;
            state_n = STUCK;
          end else begin
            cnt_n = cnt + ONE_C;
          end
        end else begin
          if ((cnt >= MIN_C) && (cnt <= MAX_C)) begin
            stout_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
          state_n = IDLE;
        end
      end
      STUCK: begin
        if (!Stin) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign Busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_pulse_checker.sv
// Self-checking bench for pulse_checker: two instances (tolerance 0 and 1)
// see the same Stin waveform; expected strobes come from pulse widths.
module tb_pulse_checker;

  logic       CLK;
  logic       RST;
  logic       Stin;
  logic       stout0, err0, busy0;
  logic       stout1, err1, busy1;
  logic [1:0] dbg0, dbg1;

  int n_tests = 0;
  int n_fail  = 0;

  // Stimulus, recorded outputs {Stout,Err,Busy} and expected outputs.
  logic       wave[$];
  logic [2:0] rec0[$], rec1[$];
  logic [2:0] exp0[$], exp1[$];

  pulse_checker #(.pulse_length(3), .tolerance(0)) dut0 (
    .CLK(CLK), .RST(RST), .Stin(Stin),
    .Stout(stout0), .Err(err0), .Busy(busy0), .dbg_state(dbg0)
  );

  pulse_checker #(.pulse_length(3), .tolerance(1)) dut1 (
    .CLK(CLK), .RST(RST), .Stin(Stin),
    .Stout(stout1), .Err(err1), .Busy(busy1), .dbg_state(dbg1)
  );

  // Clock and watchdog.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- drivers
  task automatic add(input logic v, input int n);
    for (int i = 0; i < n; i++) wave.push_back(v);
  endtask

  task automatic do_reset(input logic stin_val);
    @(negedge CLK);
    RST  = 1'b1;
    Stin = stin_val;
    repeat (2) @(posedge CLK);
  endtask

  // Drives wave[i] so it is sampled at edge i and records outputs 1 time unit
  // after that edge (i.e. what edge i registered). Releases reset first.
  task automatic drive_wave();
    rec0.delete();
    rec1.delete();
    for (int i = 0; i < wave.size(); i++) begin
      @(negedge CLK);
      RST  = 1'b0;
      Stin = wave[i];
      @(posedge CLK);
      #1;
      rec0.push_back({stout0, err0, busy0});
      rec1.push_back({stout1, err1, busy1});
    end
  endtask

  // Reference model: every high run that starts after a low sample is one
  // pulse of width w starting at index k. Busy covers k..k+w-1; an accepted or
  // short pulse strobes at k+w; a long one flags Err at k+mx.
  task automatic build_model(input int sel, input int mn, input int mx);
    logic [2:0] e[$];
    int n;
    n = wave.size();
    for (int i = 0; i < n; i++) e.push_back(3'b000);
    for (int k = 1; k < n; k++) begin
      if (wave[k] === 1'b1 && wave[k-1] === 1'b0) begin
        int w;
        w = 0;
        while (k + w < n && wave[k+w] === 1'b1) w++;
        for (int j = k; j < k + w; j++) e[j] = e[j] | 3'b001;
        if (w >= mn && w <= mx) e[k+w] = e[k+w] | 3'b100;
        else if (w < mn)        e[k+w] = e[k+w] | 3'b010;
        else                    e[k+mx] = e[k+mx] | 3'b010;
      end
    end
    if (sel == 0) exp0 = e;
    else          exp1 = e;
  endtask

  task automatic prepare();
    build_model(0, 3, 3);
    build_model(1, 2, 4);
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    @(negedge CLK);
    RST  = 1'b1;
    Stin = 1'b1;
    #1;
    n_tests++;
    if ({stout0, err0, busy0} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_async_d0: got %b want 000", {stout0, err0, busy0});
    end
    repeat (2) @(posedge CLK);
    #1;
    n_tests++;
    if ({stout0, err0, busy0, dbg0} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_hold_d0: got %b want 00000", {stout0, err0, busy0, dbg0});
    end
    n_tests++;
    if ({stout1, err1, busy1, dbg1} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_hold_d1: got %b want 00000", {stout1, err1, busy1, dbg1});
    end
  endtask

  task automatic test_valid();
    int ns;
    int ne;
    do_reset(1'b0);
    wave.delete();
    add(0, 2); add(1, 3); add(0, 4);
    prepare();
    drive_wave();
    for (int i = 0; i < wave.size(); i++) begin
      n_tests++;
      if (rec0[i] !== exp0[i]) begin
        n_fail++;
        $display("FAIL valid_d0 cyc %0d: got %b want %b", i, rec0[i], exp0[i]);
      end
      n_tests++;
      if (rec1[i] !== exp1[i]) begin
        n_fail++;
        $display("FAIL valid_d1 cyc %0d: got %b want %b", i, rec1[i], exp1[i]);
      end
    end
    ns = 0;
    ne = 0;
    for (int i = 0; i < rec0.size(); i++) begin
      ns += int'(rec0[i][2]);
      ne += int'(rec0[i][1]);
    end
    n_tests++;
    if (ns != 1 || ne != 0 || rec0[5] !== 3'b100) begin
      n_fail++;
      $display("FAIL valid_strobe: got stout=%0d err=%0d cyc5=%b want 1 0 100", ns, ne, rec0[5]);
    end
  endtask

  task automatic test_short();
    int ns;
    int ne;
    do_reset(1'b0);
    wave.delete();
    add(0, 2); add(1, 2); add(0, 3); add(1, 1); add(0, 4);
    prepare();
    drive_wave();
    for (int i = 0; i < wave.size(); i++) begin
      n_tests++;
      if (rec0[i] !== exp0[i]) begin
        n_fail++;
        $display("FAIL short_d0 cyc %0d: got %b want %b", i, rec0[i], exp0[i]);
      end
      n_tests++;
      if (rec1[i] !== exp1[i]) begin
        n_fail++;
        $display("FAIL short_d1 cyc %0d: got %b want %b", i, rec1[i], exp1[i]);
      end
    end
    ns = 0;
    ne = 0;
    for (int i = 0; i < rec0.size(); i++) begin
      ns += int'(rec0[i][2]);
      ne += int'(rec0[i][1]);
    end
    n_tests++;
    if (ns != 0 || ne != 2) begin
      n_fail++;
      $display("FAIL short_count: got stout=%0d err=%0d want 0 2", ns, ne);
    end
  endtask

  task automatic test_long();
    int ns;
    int ne;
    do_reset(1'b0);
    wave.delete();
    add(0, 2); add(1, 10); add(0, 4);
    prepare();
    drive_wave();
    for (int i = 0; i < wave.size(); i++) begin
      n_tests++;
      if (rec0[i] !== exp0[i]) begin
        n_fail++;
        $display("FAIL long_d0 cyc %0d: got %b want %b", i, rec0[i], exp0[i]);
      end
      n_tests++;
      if (rec1[i] !== exp1[i]) begin
        n_fail++;
        $display("FAIL long_d1 cyc %0d: got %b want %b", i, rec1[i], exp1[i]);
      end
    end
    ns = 0;
    ne = 0;
    for (int i = 0; i < rec0.size(); i++) begin
      ns += int'(rec0[i][2]);
      ne += int'(rec0[i][1]);
    end
    n_tests++;
    if (ns != 0 || ne != 1 || rec0[5] !== 3'b011 || rec0[11] !== 3'b001 || rec0[12] !== 3'b000) begin
      n_fail++;
      $display("FAIL long_shape: got stout=%0d err=%0d c5=%b c11=%b c12=%b want 0 1 011 001 000",
               ns, ne, rec0[5], rec0[11], rec0[12]);
    end
  endtask

  task automatic test_back_to_back();
    int pos[$];
    do_reset(1'b0);
    wave.delete();
    add(0, 2); add(1, 3); add(0, 1); add(1, 3); add(0, 4);
    prepare();
    drive_wave();
    for (int i = 0; i < wave.size(); i++) begin
      n_tests++;
      if (rec0[i] !== exp0[i]) begin
        n_fail++;
        $display("FAIL b2b_d0 cyc %0d: got %b want %b", i, rec0[i], exp0[i]);
      end
      n_tests++;
      if (rec1[i] !== exp1[i]) begin
        n_fail++;
        $display("FAIL b2b_d1 cyc %0d: got %b want %b", i, rec1[i], exp1[i]);
      end
    end
    for (int i = 0; i < rec0.size(); i++) if (rec0[i][2] === 1'b1) pos.push_back(i);
    n_tests++;
    if (pos.size() != 2 || pos[1] - pos[0] != 4) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d strobes gap %0d want 2 strobes gap 4",
               pos.size(), (pos.size() == 2) ? pos[1] - pos[0] : -1);
    end
  endtask

  task automatic test_reset_mid();
    int ns;
    int ne;
    do_reset(1'b0);
    wave.delete();
    add(0, 1); add(1, 2);
    drive_wave();
    n_tests++;
    if (rec0[2] !== 3'b001) begin
      n_fail++;
      $display("FAIL rstmid_busy_before: got %b want 001", rec0[2]);
    end
    // Assert reset in the middle of the pulse; outputs clear without a clock.
    @(negedge CLK);
    RST  = 1'b1;
    Stin = 1'b1;
    #1;
    n_tests++;
    if ({stout0, err0, busy0, stout1, err1, busy1} !== 6'b000000) begin
      n_fail++;
      $display("FAIL rstmid_async: got %b want 000000", {stout0, err0, busy0, stout1, err1, busy1});
    end
    repeat (2) @(posedge CLK);
    // Stin stays high across release, falls 3 cycles later, then a clean pulse.
    wave.delete();
    add(1, 3); add(0, 2); add(1, 3); add(0, 4);
    prepare();
    drive_wave();
    for (int i = 0; i < wave.size(); i++) begin
      n_tests++;
      if (rec0[i] !== exp0[i]) begin
        n_fail++;
        $display("FAIL rstmid_d0 cyc %0d: got %b want %b", i, rec0[i], exp0[i]);
      end
      n_tests++;
      if (rec1[i] !== exp1[i]) begin
        n_fail++;
        $display("FAIL rstmid_d1 cyc %0d: got %b want %b", i, rec1[i], exp1[i]);
      end
    end
    ns = 0;
    ne = 0;
    for (int i = 0; i < rec0.size(); i++) begin
      ns += int'(rec0[i][2]);
      ne += int'(rec0[i][1]);
    end
    n_tests++;
    if (ns != 1 || ne != 0) begin
      n_fail++;
      $display("FAIL rstmid_count: got stout=%0d err=%0d want 1 0", ns, ne);
    end
  endtask

  task automatic test_tolerance();
    int ns;
    int ne;
    do_reset(1'b0);
    wave.delete();
    add(0, 2);
    for (int w = 1; w <= 5; w++) begin
      add(1, w); add(0, 2);
    end
    add(0, 2);
    prepare();
    drive_wave();
    for (int i = 0; i < wave.size(); i++) begin
      n_tests++;
      if (rec0[i] !== exp0[i]) begin
        n_fail++;
        $display("FAIL tol_d0 cyc %0d: got %b want %b", i, rec0[i], exp0[i]);
      end
      n_tests++;
      if (rec1[i] !== exp1[i]) begin
        n_fail++;
        $display("FAIL tol_d1 cyc %0d: got %b want %b", i, rec1[i], exp1[i]);
      end
    end
    ns = 0;
    ne = 0;
    for (int i = 0; i < rec1.size(); i++) begin
      ns += int'(rec1[i][2]);
      ne += int'(rec1[i][1]);
    end
    n_tests++;
    if (ns != 3 || ne != 2) begin
      n_fail++;
      $display("FAIL tol1_count: got stout=%0d err=%0d want 3 2", ns, ne);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      do_reset(1'($urandom_range(0, 1)));
      wave.delete();
      add(1'($urandom_range(0, 1)), $urandom_range(1, 3));
      for (int p = 0; p < 5; p++) begin
        add(0, $urandom_range(1, 3));
        add(1, $urandom_range(1, 8));
      end
      add(0, 4);
      prepare();
      drive_wave();
      for (int i = 0; i < wave.size(); i++) begin
        n_tests++;
        if (rec0[i] !== exp0[i]) begin
          n_fail++;
          $display("FAIL rand%0d_d0 cyc %0d: got %b want %b", it, i, rec0[i], exp0[i]);
        end
        n_tests++;
        if (rec1[i] !== exp1[i]) begin
          n_fail++;
          $display("FAIL rand%0d_d1 cyc %0d: got %b want %b", it, i, rec1[i], exp1[i]);
        end
      end
    end
  endtask

  // ------------------------------------------------------------------- main
  initial begin
    RST  = 1'b1;
    Stin = 1'b0;
    test_reset();
    test_valid();
    test_short();
    test_long();
    test_back_to_back();
    test_reset_mid();
    test_tolerance();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
